// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding, add-3 constants and digit sizing helper for bcd_conv_ctrl
package bcd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Smallest digit count whose decimal range covers every bin_w-bit unsigned value.
  function automatic int min_digits(input int bin_w);
    longint unsigned lim;
    longint unsigned pw;
    int d;
    lim = (64'd1 << bin_w) - 64'd1;
    pw  = 64'd1;
    d   = 0;
    for (int i = 0; i < 20; i++) begin
      if (pw <= lim) begin
        pw = pw * 64'd10;
        d  = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble correction cell: add 3 to a BCD digit that is 5 or more
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Digits 5..9 get +3 so the following left shift carries into the next digit.
  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) begin
      dout = din + ADJ_ADD;
    end
  end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// rtl/bcd_conv_ctrl.sv - bit-serial binary-to-BCD converter with valid/ready handshakes; BCD_SIGNED_EN adds two's complement input and oSIGN
module bcd_conv_ctrl
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                iCLK,
  input  logic                iRSTn,
  input  logic                iVALID,
  output logic                oREADY,
  input  logic [BIN_W-1:0]    iBIN,
  output logic                oVALID,
  input  logic                iREADY,
  output logic [4*DIGITS-1:0] oBCD,
  output logic                oBUSY
`ifdef BCD_SIGNED_EN
  ,
  output logic                oSIGN
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
    $error("bcd_conv_ctrl: DIGITS too small for BIN_W");
  end

  state_t             state;
  logic [BIN_W-1:0]   bin_sr;
  logic [BIN_W-1:0]   bin_next;
  logic [BIN_W-1:0]   bin_load;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;
  logic [CNT_W-1:0]   cnt;
  logic               last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_sr[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // One double-dabble step: corrected digits and the binary word shift left together.
  assign bcd_next   = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
  assign bin_next   = {bin_sr[BIN_W-2:0], 1'b0};
  assign last_shift = (cnt == CNT_W'(1));

`ifdef BCD_SIGNED_EN
  // Magnitude in BIN_W bits; the most negative value maps to its unsigned pattern, which is its magnitude.
  assign bin_load = iBIN[BIN_W-1] ? (~iBIN + {{(BIN_W-1){1'b0}}, 1'b1}) : iBIN;
`else
  assign bin_load = iBIN;
`endif

  assign oREADY = (state == IDLE);
  assign oBUSY  = (state == SHIFT);
  assign oVALID = (state == DONE);

  // FSM, shift registers, bit counter and the result register.
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state  <= IDLE;
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      oBCD   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iVALID) begin
            bin_sr <= bin_load;
            bcd_sr <= '0;
            cnt    <= CNT_W'(BIN_W);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr <= bin_next;
          bcd_sr <= bcd_next;
          cnt    <= cnt - CNT_W'(1);
          if (last_shift) begin
            oBCD  <= bcd_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (iREADY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_SIGNED_EN
  logic sign_pend;

  // Sign is captured at accept but published together with the magnitude.
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      sign_pend <= 1'b0;
      oSIGN     <= 1'b0;
    end else begin
      if (state == IDLE && iVALID) begin
        sign_pend <= iBIN[BIN_W-1];
      end
      if (state == SHIFT && last_shift) begin
        oSIGN <= sign_pend;
      end
    end
  end
`endif

endmodule
